// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: widths, ALU opcodes and the ALU
// evaluation helper used by the execution unit.
package cpu_pkg;

  localparam int unsigned DW   = 16;       // data / address / register width
  localparam int unsigned DWX  = DW + 1;   // ALU width including carry bit
  localparam int unsigned AW   = 3;        // register file address width
  localparam int unsigned NREG = 8;        // register count
  localparam int unsigned OPW  = 4;        // ALU opcode width
  localparam int unsigned OFFW = 9;        // relative-jump offset field width in IR

  localparam logic [OPW-1:0] ALU_PASS_S = 4'b0000;
  localparam logic [OPW-1:0] ALU_PASS_R = 4'b0001;
  localparam logic [OPW-1:0] ALU_INC_S  = 4'b0010;
  localparam logic [OPW-1:0] ALU_DEC_S  = 4'b0011;
  localparam logic [OPW-1:0] ALU_ADD    = 4'b0100;
  localparam logic [OPW-1:0] ALU_SUB    = 4'b0101;
  localparam logic [OPW-1:0] ALU_SHR    = 4'b0110;
  localparam logic [OPW-1:0] ALU_SHL    = 4'b0111;
  localparam logic [OPW-1:0] ALU_AND    = 4'b1000;
  localparam logic [OPW-1:0] ALU_OR     = 4'b1001;
  localparam logic [OPW-1:0] ALU_XOR    = 4'b1010;
  localparam logic [OPW-1:0] ALU_NOT    = 4'b1011;
  localparam logic [OPW-1:0] ALU_ZERO   = 4'b1100;

  typedef struct packed {
    logic [DW-1:0] y;
    logic          c;
  } alu_res_t;

  // ALU result and carry; subtract-style ops report borrow in bit DW of the wide result
  function automatic alu_res_t alu_eval(input logic [OPW-1:0] op,
                                        input logic [DW-1:0]  r,
                                        input logic [DW-1:0]  s);
    alu_res_t      res;
    logic [DW:0]   ext;
    res = '0;
    ext = '0;
    case (op)
      ALU_PASS_S: res.y = s;
      ALU_PASS_R: res.y = r;
      ALU_INC_S: begin
        ext   = {1'b0, s} + DWX'(1);
        res.y = ext[DW-1:0];
        res.c = ext[DW];
      end
      ALU_DEC_S: begin
        ext   = {1'b0, s} - DWX'(1);
        res.y = ext[DW-1:0];
        res.c = ext[DW];
      end
      ALU_ADD: begin
        ext   = {1'b0, r} + {1'b0, s};
        res.y = ext[DW-1:0];
        res.c = ext[DW];
      end
      ALU_SUB: begin
        ext   = {1'b0, r} - {1'b0, s};
        res.y = ext[DW-1:0];
        res.c = ext[DW];
      end
      ALU_SHR: begin
        res.y = {1'b0, s[DW-1:1]};
        res.c = s[0];
      end
      ALU_SHL: begin
        res.y = {s[DW-2:0], 1'b0};
        res.c = s[DW-1];
      end
      ALU_AND:  res.y = r & s;
      ALU_OR:   res.y = r | s;
      ALU_XOR:  res.y = r ^ s;
      ALU_NOT:  res.y = ~s;
      ALU_ZERO: res   = '0;
      default:  res   = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/reg_file8x16.sv
// Eight-entry register file.
// Ports: clk, rst_n (async active-low clear of all entries),
//        we_i/w_adr_i/w_data_i (synchronous write port),
//        r_adr_i/r_data_c_o and s_adr_i/s_data_c_o (combinational read ports).
// A read of the entry being written returns the pre-edge contents.
module reg_file8x16
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] w_adr_i,
  input  logic [DW-1:0] w_data_i,
  input  logic [AW-1:0] r_adr_i,
  input  logic [AW-1:0] s_adr_i,
  output logic [DW-1:0] r_data_c_o,
  output logic [DW-1:0] s_data_c_o
);

  logic [DW-1:0] regs_q [NREG];

  // storage: cleared on reset, single write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[w_adr_i] <= w_data_i;
    end
  end

  assign r_data_c_o = regs_q[r_adr_i];
  assign s_data_c_o = regs_q[s_adr_i];

endmodule

// File: rtl/cpu_eu.sv
// Execution unit of the 16-bit CPU: register file, ALU, PC and IR.
// Inputs : clk, reset (async active-low), control word
//          {W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
//           ir_ld, mw_en, rw_en, alu_op}, D_in (memory read data).
// Outputs: IR, pc_out (registered); N/Z/C, Address, D_out, mem_we
//          (combinational from the control word and current state).
module cpu_eu
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [AW-1:0]  W_Adr,
  input  logic [AW-1:0]  R_Adr,
  input  logic [AW-1:0]  S_Adr,
  input  logic           adr_sel,
  input  logic           s_sel,
  input  logic           pc_ld,
  input  logic           pc_inc,
  input  logic           pc_sel,
  input  logic           ir_ld,
  input  logic           mw_en,
  input  logic           rw_en,
  input  logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  D_in,
  output logic [DW-1:0]  IR,
  output logic           N,
  output logic           Z,
  output logic           C,
  output logic [DW-1:0]  Address,
  output logic [DW-1:0]  D_out,
  output logic           mem_we,
  output logic [DW-1:0]  pc_out
);

  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] r_port, s_port, s_opnd, pc_rel;
  alu_res_t      alu;

  reg_file8x16 u_rf (
    .clk        (clk),
    .rst_n      (reset),
    .we_i       (rw_en),
    .w_adr_i    (W_Adr),
    .w_data_i   (alu.y),
    .r_adr_i    (R_Adr),
    .s_adr_i    (S_Adr),
    .r_data_c_o (r_port),
    .s_data_c_o (s_port)
  );

  // operand select and ALU
  assign s_opnd = s_sel ? D_in : s_port;
  assign alu    = alu_eval(alu_op, r_port, s_opnd);

  assign N       = alu.y[DW-1];
  assign Z       = (alu.y == '0);
  assign C       = alu.c;
  assign Address = adr_sel ? r_port : pc_q;
  assign D_out   = s_port;
  assign mem_we  = mw_en;
  assign IR      = ir_q;
  assign pc_out  = pc_q;

  // relative target uses the current PC, which a fetch has already advanced
  assign pc_rel = pc_q + {{(DW-OFFW){ir_q[OFFW-1]}}, ir_q[OFFW-1:0]};

  // next PC / IR: load beats increment
  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    if (pc_ld) begin
      pc_d = pc_sel ? alu.y : pc_rel;
    end else if (pc_inc) begin
      pc_d = pc_q + DW'(1);
    end
    if (ir_ld) begin
      ir_d = D_in;
    end
  end

  // PC and IR registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

endmodule

// File: doc/cpu_eu.md
# cpu_eu

Execution unit of the 16-bit CPU: holds the eight-entry register file, ALU, program counter (PC) and instruction register (IR). It sits directly downstream of the control unit. Each cycle it consumes the control word `{W_Adr, R_Adr, S_Adr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en, alu_op}`. It returns `IR` and the combinational `N/Z/C` flags to the control unit and drives the memory address and write-data buses.

## Interface
- `DW`, 16: data, address and register width.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `W_Adr`, `R_Adr`, `S_Adr`  in  3 each  register file write address, R-port read address and S-port read address.
- `adr_sel`  in  1  memory address select: 0 = PC, 1 = R-port.
- `s_sel`  in  1  ALU S-operand select: 0 = S-port, 1 = `D_in`.
- `pc_ld`, `pc_inc`, `pc_sel`  in  1 each  PC load, PC increment and PC load source (0 = PC + sext(IR[8:0]), 1 = ALU out).
- `ir_ld`  in  1  load `D_in` into IR.
- `rw_en`  in  1  register file write enable.
- `mw_en`  in  1  memory write enable; forwarded unchanged as `mem_we`.
- `alu_op`  in  4  ALU function.
- `D_in`  in  16  memory read data (combinational memory read).
- `IR`  out  16  instruction register.
- `N`, `Z`, `C`  out  1 each  combinational ALU flags.
- `Address`  out  16  memory address.
- `D_out`  out  16  memory write data, equal to S-port.
- `mem_we`  out  1  equal to `mw_en`.
- `pc_out`  out  16  current PC, for debug display.

## Operation
- Register file: R0–R7, 16 bits each. R0 is an ordinary register.
  - Reads are combinational on both R and S ports.
  - Writes occur at the clock edge when `rw_en`=1, storing the ALU output to `W_Adr`.
  - A read of an address being written in the same cycle returns the old value.
- Operands: R = R-port. S = `D_in` when `s_sel`=1, otherwise S-port.
- ALU output `Y` and carry `C` by `alu_op`:
  - 0000: Y = S, C = 0.
  - 0001: Y = R, C = 0.
  - 0010: Y = S+1, C = carry-out.
  - 0011: Y = S−1, C = borrow (set when S==0).
  - 0100: Y = R+S, C = bit 16 of the 17-bit sum.
  - 0101: Y = R−S, C = borrow (set when R<S, unsigned).
  - 0110: Y = S>>1 with 0 fill, C = S[0].
  - 0111: Y = S<<1, C = S[15].
  - 1000: Y = R&S. 1001: Y = R|S. 1010: Y = R^S. 1011: Y = ~S. For all four, C = 0.
  - 1100–1111: Y = 0, C = 0.
  - For every op: N = Y[15], Z = (Y==0).
- `Address` = R-port when `adr_sel`=1, otherwise PC.
- PC update, in priority order:
  - `pc_ld`=1: PC ← ALU Y when `pc_sel`=1, otherwise PC + sext(IR[8:0]) (mod 2^16).
  - else `pc_inc`=1: PC ← PC+1 (mod 2^16; 0xFFFF wraps to 0x0000).
  - else PC holds.
- IR ← `D_in` when `ir_ld`=1.
- IR, PC and register writes can all occur in the same cycle. Each uses pre-edge values.
- Flags are not stored here; the control unit latches them.

## Timing
- Reset (`reset`=0, asynchronous): PC = 0, IR = 0, R0–R7 = 0.
  - Outputs after reset: `Address` = 0, `D_out` = 0, `pc_out` = 0.
  - `N/Z/C` follow the inputs.
- Deasserting reset mid-instruction restarts cleanly from PC = 0.
- Latency:
  - `Address`, `D_out`, `N/Z/C` and `mem_we` are combinational, with zero latency from the control word.
  - PC, IR and register file updates are visible one cycle after the asserting edge.
- Fetch cycle (`ir_ld`=1, `pc_inc`=1, `adr_sel`=0): IR captures mem[PC] and PC advances in the same edge.
- Relative jump offsets are therefore relative to the already-incremented PC.
- LDI (`s_sel`=1, `adr_sel`=0, `pc_inc`=1, `rw_en`=1): writes mem[PC] to `W_Adr` and skips past the immediate word.

## Structure
- Shared package `cpu_pkg`:
  - ALU opcode constants (`ALU_PASS_S` … `ALU_ZERO`).
  - Data width `DW`.
  - Register address width 3.
- Sub-module `reg_file8x16`: two combinational read ports, one synchronous write port, asynchronous active-low reset.
- ALU, operand muxes, PC and IR stay in `cpu_eu`.

## Test plan
- Reset: hold `reset`=0 mid-run with PC = 0x0012 → PC = 0, IR = 0 and all registers read 0 immediately, without waiting for a clock edge.
- Fetch: mem[0] = 0xE0C5 with `ir_ld`=`pc_inc`=1 for one cycle → IR = 0xE0C5, PC = 1.
- ADD/SUB flags:
  - R1 = 0xFFFF, R2 = 0x0001, `alu_op`=0100, W = 3 → R3 = 0x0000, Z = 1, C = 1, N = 0.
  - `alu_op`=0101 with R = 0x0001, S = 0x0002 → Y = 0xFFFF, N = 1, C = 1.
- LD/STO:
  - `adr_sel`=1, R-port = 0x0040, `mw_en`=1, S-port = 0xBEEF → mem[0x40] = 0xBEEF.
  - Then LD (`s_sel`=1, `rw_en`=1) → destination register = 0xBEEF.
- Jumps:
  - PC = 0x0010, IR[8:0] = 0x1FE, `pc_ld`=1, `pc_sel`=0 → PC = 0x000E.
  - `pc_sel`=1 with R = 0x0123, `alu_op`=0001 → PC = 0x0123.
  - `pc_ld` and `pc_inc` both asserted → load wins.
- Boundaries:
  - PC = 0xFFFF with `pc_inc` → PC = 0x0000.
  - Write R4 while reading R4 in the same cycle → old value read, new value visible next cycle.
